// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the ID-stage hazard scoreboard.
//   - REG_ADDR_W_DEF : default register-specifier width
//   - lat_class_e    : producer latency class (ALU, load, multiply)
//   - NEED_BRANCH / NEED_NORMAL : counter value at/above which a source is busy
//   - lat_class()/lat_cycles() : classify a producer and map it to a latency
package hazard_pkg;

    localparam int unsigned REG_ADDR_W_DEF = 5;

    typedef enum logic [1:0] {
        LAT_ALU  = 2'd0,
        LAT_LOAD = 2'd1,
        LAT_MUL  = 2'd2
    } lat_class_e;

    // Branches compare in ID, so they need the value one cycle earlier than EX.
    localparam int unsigned NEED_BRANCH = 1;
    localparam int unsigned NEED_NORMAL = 2;

    // Multiply wins over load when both flags are set.
    function automatic lat_class_e lat_class(input logic memread, input logic mul);
        lat_class_e cls;
        cls = LAT_ALU;
        if (mul) begin
            cls = LAT_MUL;
        end else if (memread) begin
            cls = LAT_LOAD;
        end
        return cls;
    endfunction

    function automatic int unsigned lat_cycles(input lat_class_e cls,
                                               input int unsigned alu_lat,
                                               input int unsigned load_lat,
                                               input int unsigned mul_lat);
        int unsigned lat;
        lat = alu_lat;
        case (cls)
            LAT_LOAD: lat = load_lat;
            LAT_MUL:  lat = mul_lat;
            default:  lat = alu_lat;
        endcase
        return lat;
    endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// hazard_sb_entry: one scoreboard countdown counter.
//   clk, rst  : clock, asynchronous active-high reset (clears the counter)
//   i_load    : write a new producer latency this cycle (wins over decrement)
//   i_val     : latency value to load
//   o_cnt     : cycles remaining until the register's value is forwardable
module hazard_sb_entry #(
    parameter int unsigned CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic [CW-1:0] i_val,
    output logic [CW-1:0] o_cnt
);

    logic [CW-1:0] r_cnt;

    // Load overrides; otherwise count down and hold at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: ID-stage issue/stall decision from a per-register
// countdown scoreboard supporting ALU, load and multi-cycle multiply producers.
//   clk, rst             : clock, asynchronous active-high reset
//   id_valid             : ID holds a real instruction
//   id_rs/id_rt          : source specifiers, qualified by id_use_rs/id_use_rt
//   id_branch            : operands needed in ID (beq/bne)
//   id_regwrite/id_dst   : instruction writes id_dst
//   id_memread/id_mul    : producer latency class (mul has priority)
//   stall/id_bubble      : freeze PC and IF/ID, zero ID/EX controls (combinational)
//   issue                : id_valid & ~stall (combinational)
//   stall_cnt            : stall-cycle counter, only with HAZARD_PERF_EN defined
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int unsigned ALU_LAT    = 1,
    parameter int unsigned LOAD_LAT   = 2,
    parameter int unsigned MUL_LAT    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_use_rs,
    input  logic                  id_use_rt,
    input  logic                  id_branch,
    input  logic                  id_regwrite,
    input  logic [REG_ADDR_W-1:0] id_dst,
    input  logic                  id_memread,
    input  logic                  id_mul,
    output logic                  stall,
    output logic                  id_bubble,
    output logic                  issue
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]           stall_cnt
`endif
);

    localparam int unsigned NUM_REGS = 2 ** REG_ADDR_W;
    localparam int unsigned CW       = $clog2(MUL_LAT + 1);

    logic [CW-1:0] w_cnt [NUM_REGS];
    lat_class_e    w_cls;
    logic [CW-1:0] w_lat;
    logic [31:0]   w_need;
    logic          w_rs_busy;
    logic          w_rt_busy;
    logic          w_stall;
    logic          w_wr_en;

    // $zero is never tracked, so it can never create a hazard.
    assign w_cnt[0] = '0;

    assign w_cls  = lat_class(id_memread, id_mul);
    assign w_lat  = CW'(lat_cycles(w_cls, ALU_LAT, LOAD_LAT, MUL_LAT));
    assign w_need = id_branch ? NEED_BRANCH : NEED_NORMAL;

    // Read muxes and slack compare for both sources.
    assign w_rs_busy = id_use_rs & (32'(w_cnt[id_rs]) >= w_need);
    assign w_rt_busy = id_use_rt & (32'(w_cnt[id_rt]) >= w_need);

    assign w_stall   = id_valid & (w_rs_busy | w_rt_busy);
    assign stall     = w_stall;
    assign id_bubble = w_stall;
    assign issue     = id_valid & ~w_stall;

    // Only an issuing writer of a nonzero register updates the scoreboard.
    assign w_wr_en = id_valid & ~w_stall & id_regwrite & (id_dst != '0);

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
        hazard_sb_entry #(
            .CW(CW)
        ) u_entry (
            .clk   (clk),
            .rst   (rst),
            .i_load(w_wr_en && (id_dst == REG_ADDR_W'(r))),
            .i_val (w_lat),
            .o_cnt (w_cnt[r])
        );
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] r_stall_cnt;

    // Free-running stall-cycle count, wraps modulo 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: table-driven, hand-sequenced and randomized checks of
// hazard_scoreboard against a timestamp-based reference model.
module tb_hazard_scoreboard;

    localparam int unsigned AW       = 5;
    localparam int unsigned ALU_LAT  = 1;
    localparam int unsigned LOAD_LAT = 2;
    localparam int unsigned MUL_LAT  = 4;
    localparam int unsigned NREG     = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid;
    logic [AW-1:0] id_rs;
    logic [AW-1:0] id_rt;
    logic          id_use_rs;
    logic          id_use_rt;
    logic          id_branch;
    logic          id_regwrite;
    logic [AW-1:0] id_dst;
    logic          id_memread;
    logic          id_mul;
    logic          stall;
    logic          id_bubble;
    logic          issue;
`ifdef HAZARD_PERF_EN
    logic [31:0]   stall_cnt;
`endif

    hazard_scoreboard #(
        .REG_ADDR_W(AW),
        .ALU_LAT   (ALU_LAT),
        .LOAD_LAT  (LOAD_LAT),
        .MUL_LAT   (MUL_LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_use_rs  (id_use_rs),
        .id_use_rt  (id_use_rt),
        .id_branch  (id_branch),
        .id_regwrite(id_regwrite),
        .id_dst     (id_dst),
        .id_memread (id_memread),
        .id_mul     (id_mul),
        .stall      (stall),
        .id_bubble  (id_bubble),
        .issue      (issue)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          valid;
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        logic          use_rs;
        logic          use_rt;
        logic          branch;
        logic          regwrite;
        logic [AW-1:0] dst;
        logic          memread;
        logic          mul;
        logic          exp_stall;
        logic          exp_issue;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    // Reference model: each register remembers when and with which latency
    // it was last written; a source is busy while fewer than lat+2-need
    // cycles have elapsed since that write.
    int cyc;
    int wr_cyc [NREG];
    int wr_lat [NREG];

    function automatic void model_reset();
        for (int r = 0; r < int'(NREG); r++) begin
            wr_cyc[r] = -1000;
            wr_lat[r] = 0;
        end
    endfunction

    function automatic bit busy(input int r, input int need);
        if (r == 0) return 1'b0;
        return (cyc - wr_cyc[r]) < (wr_lat[r] + 2 - need);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic v, input int rs, input int rt,
                                input logic urs, input logic urt, input logic br,
                                input logic rw, input int dst, input logic mr,
                                input logic ml, input logic es, input logic ei);
        vec_t x;
        x.valid = v;       x.rs = AW'(rs);      x.rt = AW'(rt);
        x.use_rs = urs;    x.use_rt = urt;      x.branch = br;
        x.regwrite = rw;   x.dst = AW'(dst);    x.memread = mr;
        x.mul = ml;        x.exp_stall = es;    x.exp_issue = ei;
        return x;
    endfunction

    task automatic apply(input vec_t v);
        id_valid = v.valid;       id_rs = v.rs;         id_rt = v.rt;
        id_use_rs = v.use_rs;     id_use_rt = v.use_rt; id_branch = v.branch;
        id_regwrite = v.regwrite; id_dst = v.dst;       id_memread = v.memread;
        id_mul = v.mul;
    endtask

    // Called 1ns after a rising edge with inputs applied; checks mid-cycle,
    // then advances the model across the next rising edge.
    task automatic run_cycle(input string tag, input bit has_exp, input logic es, input logic ei);
        logic ms;
        logic mi;
        int   need;
        #4;
        need = id_branch ? 1 : 2;
        ms = id_valid && ((id_use_rs && busy(int'(id_rs), need)) ||
                          (id_use_rt && busy(int'(id_rt), need)));
        mi = id_valid && !ms;
        chk({tag, "_stall"},  {31'd0, stall},     {31'd0, ms});
        chk({tag, "_bubble"}, {31'd0, id_bubble}, {31'd0, ms});
        chk({tag, "_issue"},  {31'd0, issue},     {31'd0, mi});
        if (has_exp) begin
            chk({tag, "_tbl_stall"}, {31'd0, stall}, {31'd0, es});
            chk({tag, "_tbl_issue"}, {31'd0, issue}, {31'd0, ei});
        end
        @(posedge clk);
        if (!rst && mi && id_regwrite && id_dst != '0) begin
            wr_cyc[id_dst] = cyc;
            wr_lat[id_dst] = id_mul ? int'(MUL_LAT) : (id_memread ? int'(LOAD_LAT) : int'(ALU_LAT));
        end
        cyc++;
        #1;
    endtask

    vec_t tbl [30];
    vec_t lw8, add9, beq89, add_8;

    initial begin
        // lw $8 ; add $9,$8,$10 ; beq $8,$9 ; add $16,$8,$0
        lw8   = mk(1, 29, 0, 1, 0, 0, 1, 8, 1, 0, 0, 1);
        add9  = mk(1, 8, 10, 1, 1, 0, 1, 9, 0, 0, 0, 1);
        beq89 = mk(1, 8, 9, 1, 1, 1, 0, 0, 0, 0, 0, 1);
        add_8 = mk(1, 8, 0, 1, 1, 0, 1, 16, 0, 0, 0, 1);

        // Load-use, ALU-branch, load-branch, mul-use, override, $zero, flush,
        // mul priority over memread, unused source.
        tbl[0]  = mk(1, 29, 0, 1, 0, 0, 1, 8, 1, 0, 0, 1);
        tbl[1]  = mk(1, 8, 10, 1, 1, 0, 1, 9, 0, 0, 1, 0);
        tbl[2]  = mk(1, 8, 10, 1, 1, 0, 1, 9, 0, 0, 0, 1);
        tbl[3]  = mk(1, 8, 9, 1, 1, 1, 0, 0, 0, 0, 1, 0);
        tbl[4]  = mk(1, 8, 9, 1, 1, 1, 0, 0, 0, 0, 0, 1);
        tbl[5]  = mk(1, 29, 0, 1, 0, 0, 1, 8, 1, 0, 0, 1);
        tbl[6]  = mk(1, 8, 9, 1, 1, 1, 0, 0, 0, 0, 1, 0);
        tbl[7]  = mk(1, 8, 9, 1, 1, 1, 0, 0, 0, 0, 1, 0);
        tbl[8]  = mk(1, 8, 9, 1, 1, 1, 0, 0, 0, 0, 0, 1);
        tbl[9]  = mk(1, 11, 12, 1, 1, 0, 1, 10, 0, 1, 0, 1);
        tbl[10] = mk(1, 10, 12, 1, 1, 0, 1, 13, 0, 0, 1, 0);
        tbl[11] = mk(1, 10, 12, 1, 1, 0, 1, 13, 0, 0, 1, 0);
        tbl[12] = mk(1, 10, 12, 1, 1, 0, 1, 13, 0, 0, 1, 0);
        tbl[13] = mk(1, 10, 12, 1, 1, 0, 1, 13, 0, 0, 0, 1);
        tbl[14] = mk(1, 11, 12, 1, 1, 0, 1, 10, 0, 1, 0, 1);
        tbl[15] = mk(1, 14, 0, 1, 0, 0, 1, 10, 0, 0, 0, 1);
        tbl[16] = mk(1, 10, 0, 1, 1, 0, 1, 15, 0, 0, 0, 1);
        tbl[17] = mk(1, 29, 0, 1, 0, 0, 1, 0, 1, 0, 0, 1);
        tbl[18] = mk(1, 0, 0, 1, 1, 0, 1, 16, 0, 0, 0, 1);
        tbl[19] = mk(1, 29, 0, 1, 0, 0, 1, 8, 1, 0, 0, 1);
        tbl[20] = mk(1, 8, 0, 1, 1, 0, 1, 16, 0, 0, 1, 0);
        tbl[21] = mk(0, 8, 0, 1, 1, 0, 1, 16, 0, 0, 0, 0);
        tbl[22] = mk(1, 8, 0, 1, 1, 0, 1, 16, 0, 0, 0, 1);
        tbl[23] = mk(1, 0, 0, 0, 0, 0, 1, 17, 1, 1, 0, 1);
        tbl[24] = mk(1, 0, 17, 0, 1, 0, 1, 18, 0, 0, 1, 0);
        tbl[25] = mk(1, 0, 17, 0, 1, 0, 1, 18, 0, 0, 1, 0);
        tbl[26] = mk(1, 0, 17, 0, 1, 0, 1, 18, 0, 0, 1, 0);
        tbl[27] = mk(1, 0, 17, 0, 1, 0, 1, 18, 0, 0, 0, 1);
        tbl[28] = mk(1, 29, 0, 1, 0, 0, 1, 19, 1, 0, 0, 1);
        tbl[29] = mk(1, 19, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1);

        // Reset state with ID empty.
        cyc = 0;
        model_reset();
        rst = 1'b1;
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #2;
        chk("rst_stall",  {31'd0, stall},     32'd0);
        chk("rst_bubble", {31'd0, id_bubble}, 32'd0);
        chk("rst_issue",  {31'd0, issue},     32'd0);
`ifdef HAZARD_PERF_EN
        chk("rst_stall_cnt", stall_cnt, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 30; i++) begin
            apply(tbl[i]);
            run_cycle($sformatf("tbl%0d", i), 1'b1, tbl[i].exp_stall, tbl[i].exp_issue);
        end

        // Reset asserted during a load-use stall.
        apply(lw8);
        run_cycle("rm_lw", 1'b1, 1'b0, 1'b1);
        apply(add9);
        #4;
        chk("rm_pre_stall", {31'd0, stall}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rm_in_rst_stall",  {31'd0, stall},     32'd0);
        chk("rm_in_rst_bubble", {31'd0, id_bubble}, 32'd0);
        chk("rm_in_rst_issue",  {31'd0, issue},     32'd1);
        model_reset();
        @(posedge clk);
        cyc++;
        #1;
        rst = 1'b0;
        run_cycle("rm_after", 1'b1, 1'b0, 1'b1);

        // Randomized traffic over a small register window to provoke hazards.
        for (int n = 0; n < 3000; n++) begin
            vec_t v;
            v.valid    = ($urandom_range(0, 9) != 0);
            v.rs       = AW'($urandom_range(0, 7));
            v.rt       = AW'($urandom_range(0, 7));
            v.use_rs   = 1'($urandom_range(0, 1));
            v.use_rt   = 1'($urandom_range(0, 1));
            v.branch   = ($urandom_range(0, 3) == 0);
            v.regwrite = ($urandom_range(0, 3) != 0);
            v.dst      = AW'($urandom_range(0, 7));
            v.memread  = ($urandom_range(0, 3) == 0);
            v.mul      = ($urandom_range(0, 4) == 0);
            v.exp_stall = 1'b0;
            v.exp_issue = 1'b0;
            rst = ($urandom_range(0, 99) == 0);
            if (rst) model_reset();
            apply(v);
            run_cycle($sformatf("rnd%0d", n), 1'b0, 1'b0, 1'b0);
            rst = 1'b0;
        end

`ifdef HAZARD_PERF_EN
        // Load-branch (2 stalls) then load-use (1 stall).
        rst = 1'b1;
        model_reset();
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        cyc++;
        #1;
        rst = 1'b0;
        apply(lw8);   run_cycle("pf_lw0", 1'b1, 1'b0, 1'b1);
        apply(beq89); run_cycle("pf_b0",  1'b1, 1'b1, 1'b0);
        apply(beq89); run_cycle("pf_b1",  1'b1, 1'b1, 1'b0);
        apply(beq89); run_cycle("pf_b2",  1'b1, 1'b0, 1'b1);
        apply(lw8);   run_cycle("pf_lw1", 1'b1, 1'b0, 1'b1);
        apply(add_8); run_cycle("pf_a0",  1'b1, 1'b1, 1'b0);
        apply(add_8); run_cycle("pf_a1",  1'b1, 1'b0, 1'b1);
        chk("pf_stall_cnt", stall_cnt, 32'd3);

        // Wrap from all-ones on the next stall cycle.
        force dut.r_stall_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_stall_cnt;
        apply(lw8);   run_cycle("pw_lw", 1'b1, 1'b0, 1'b1);
        chk("pw_preload", stall_cnt, 32'hFFFF_FFFF);
        apply(add_8); run_cycle("pw_a0", 1'b1, 1'b1, 1'b0);
        chk("pw_wrap", stall_cnt, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
